// File: rtl/sha1_hash.sv
// Sequential SHA-1 engine: one compression round per clock over NUM pre-padded
// 512-bit blocks presented in parallel; digest returned on sha_res with a done pulse.
module sha1_hash #(
  parameter int NUM = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [NUM*512-1:0] data,
  output logic               busy,
  output logic               done,
  output logic [159:0]       sha_res
);

  localparam int BW = $clog2(NUM + 1);
  localparam logic [159:0] IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL} state_t;

  state_t             state_q;
  logic [6:0]         rnd_q;
  logic [BW-1:0]      blk_q;
  logic [31:0]        h_q [5];
  logic [31:0]        a_q, b_q, c_q, d_q, e_q;
  logic [31:0]        w_q [16];
  logic [NUM*512-1:0] data_q;
  logic               busy_q, done_q;
  logic [159:0]       res_q;

  logic [31:0]  f_d, k_d, temp_d, wnew_d, wx_d;
  logic [31:0]  hsum_d [5];
  logic [511:0] first_blk, next_blk;

  assign first_blk = data[NUM*512-1 -: 512];
  // data_q is kept pre-shifted so the next block to load always sits in the top 512 bits.
  assign next_blk  = data_q[NUM*512-1 -: 512];

  always_comb begin
    f_d = '0;
    k_d = '0;
    if (rnd_q < 7'd20) begin
      f_d = (b_q & c_q) | (~b_q & d_q);
      k_d = 32'h5A827999;
    end else if (rnd_q < 7'd40) begin
      f_d = b_q ^ c_q ^ d_q;
      k_d = 32'h6ED9EBA1;
    end else if (rnd_q < 7'd60) begin
      f_d = (b_q & c_q) | (b_q & d_q) | (c_q & d_q);
      k_d = 32'h8F1BBCDC;
    end else begin
      f_d = b_q ^ c_q ^ d_q;
      k_d = 32'hCA62C1D6;
    end
    temp_d    = {a_q[26:0], a_q[31:27]} + f_d + e_q + k_d + w_q[0];
    wx_d      = w_q[13] ^ w_q[8] ^ w_q[2] ^ w_q[0];
    wnew_d    = {wx_d[30:0], wx_d[31]};
    hsum_d[0] = h_q[0] + a_q;
    hsum_d[1] = h_q[1] + b_q;
    hsum_d[2] = h_q[2] + c_q;
    hsum_d[3] = h_q[3] + d_q;
    hsum_d[4] = h_q[4] + e_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rnd_q   <= '0;
      blk_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      e_q     <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
      for (int unsigned i = 0; i < 5; i++) h_q[i] <= '0;
      for (int unsigned i = 0; i < 16; i++) w_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            for (int unsigned i = 0; i < 5; i++) h_q[i] <= IV[159-32*i -: 32];
            a_q    <= IV[159:128];
            b_q    <= IV[127:96];
            c_q    <= IV[95:64];
            d_q    <= IV[63:32];
            e_q    <= IV[31:0];
            for (int unsigned i = 0; i < 16; i++) w_q[i] <= first_blk[511-32*i -: 32];
            data_q  <= data << 512;
            rnd_q   <= '0;
            blk_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_ROUND;
          end
        end
        S_ROUND: begin
          a_q <= temp_d;
          b_q <= a_q;
          c_q <= {b_q[1:0], b_q[31:2]};
          d_q <= c_q;
          e_q <= d_q;
          for (int unsigned i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
          w_q[15] <= wnew_d;
          if (rnd_q == 7'd79) state_q <= S_FINAL;
          else rnd_q <= rnd_q + 7'd1;
        end
        S_FINAL: begin
          for (int unsigned i = 0; i < 5; i++) h_q[i] <= hsum_d[i];
          if (blk_q == BW'(NUM - 1)) begin
            res_q   <= {hsum_d[0], hsum_d[1], hsum_d[2], hsum_d[3], hsum_d[4]};
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            a_q <= hsum_d[0];
            b_q <= hsum_d[1];
            c_q <= hsum_d[2];
            d_q <= hsum_d[3];
            e_q <= hsum_d[4];
            for (int unsigned i = 0; i < 16; i++) w_q[i] <= next_blk[511-32*i -: 32];
            data_q  <= data_q << 512;
            blk_q   <= blk_q + BW'(1);
            rnd_q   <= '0;
            state_q <= S_ROUND;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign sha_res = res_q;

endmodule

// File: tb/tb_sha1_hash.sv
// Directed + random bench for sha1_hash (NUM=1 and NUM=2 instances) against a
// plain SHA-1 compression model using a full 80-word schedule.
module tb_sha1_hash;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start1 = 1'b0, start2 = 1'b0;
  logic [511:0]  data1 = '0;
  logic [1023:0] data2 = '0;
  logic          busy1, done1, busy2, done2;
  logic [159:0]  res1, res2;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sha1_hash #(.NUM(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .data(data1),
    .busy(busy1), .done(done1), .sha_res(res1)
  );

  sha1_hash #(.NUM(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .data(data2),
    .busy(busy2), .done(done2), .sha_res(res2)
  );

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [159:0] sha1_model(input logic [1023:0] msg, input int nblk);
    logic [31:0] h [5];
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, tmp;
    h[0] = 32'h67452301; h[1] = 32'hEFCDAB89; h[2] = 32'h98BADCFE;
    h[3] = 32'h10325476; h[4] = 32'hC3D2E1F0;
    for (int blk = 0; blk < nblk; blk++) begin
      for (int t = 0; t < 16; t++) w[t] = msg[1023 - 512*blk - 32*t -: 32];
      for (int t = 16; t < 80; t++) w[t] = rotl(w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16], 1);
      a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4];
      for (int t = 0; t < 80; t++) begin
        if (t < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
        else if (t < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
        else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
        else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
        tmp = rotl(a, 5) + f + e + k + w[t];
        e = d; d = c; c = rotl(b, 30); b = a; a = tmp;
      end
      h[0] += a; h[1] += b; h[2] += c; h[3] += d; h[4] += e;
    end
    return {h[0], h[1], h[2], h[3], h[4]};
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start on the selected instance; returns with the sample just after E0.
  task automatic launch(input int sel);
    if (sel == 1) start1 = 1'b1; else start2 = 1'b1;
    step();
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  // Counts edges after E0 until done; lat = -1 when the budget expires.
  task automatic wait_done(input int sel, input int budget, output int lat, output int busy_cnt);
    logic d, b;
    lat = -1;
    busy_cnt = 0;
    for (int i = 1; i <= budget; i++) begin
      step();
      d = (sel == 1) ? done1 : done2;
      b = (sel == 1) ? busy1 : busy2;
      if (b) busy_cnt++;
      if (d) begin
        lat = i;
        break;
      end
    end
  endtask

  logic [511:0]  abc_blk, empty_blk, rnd_blk;
  logic [1023:0] two_blk, rnd2;
  logic [159:0]  abc_dig, empty_dig, two_dig;
  int lat, bcnt, dcnt;

  initial begin
    abc_blk   = '0;
    abc_blk[511:480] = 32'h61626380;
    abc_blk[31:0]    = 32'h00000018;
    empty_blk = '0;
    empty_blk[511:480] = 32'h80000000;
    two_blk = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
               32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
               32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
               32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000,
               448'h0, 64'h1C0};
    abc_dig   = 160'hA9993E364706816ABA3E25717850C26C9CD0D89D;
    empty_dig = 160'hDA39A3EE5E6B4B0D3255BFEF95601890AFD80709;
    two_dig   = 160'h84983E441C3BD26EBAAE4AA1F95129E5E54670F1;

    // Reset state
    step(); step();
    chk("rst_busy1", 160'(busy1), 160'(0));
    chk("rst_done1", 160'(done1), 160'(0));
    chk("rst_res1", res1, '0);
    chk("rst_res2", res2, '0);
    #2 rst_n = 1'b1;
    step();

    // "abc", NUM=1
    data1 = abc_blk;
    launch(1);
    chk("abc_busy_e0", 160'(busy1), 160'(1));
    wait_done(1, 200, lat, bcnt);
    chk_int("abc_latency", lat, 81);
    chk_int("abc_busy_cycles", bcnt, 80);
    chk("abc_busy_at_done", 160'(busy1), 160'(0));
    chk("abc_digest", res1, abc_dig);
    step();
    chk("abc_done_width", 160'(done1), 160'(0));
    chk("abc_hold", res1, abc_dig);

    // Two-block message, NUM=2
    data2 = two_blk;
    launch(2);
    wait_done(2, 400, lat, bcnt);
    chk_int("two_latency", lat, 162);
    chk_int("two_busy_cycles", bcnt, 161);
    chk("two_digest", res2, two_dig);

    // Empty message
    data1 = empty_blk;
    launch(1);
    wait_done(1, 200, lat, bcnt);
    chk_int("empty_latency", lat, 81);
    chk("empty_digest", res1, empty_dig);

    // Data change + start while busy are both ignored
    data1 = abc_blk;
    launch(1);
    for (int i = 0; i < 10; i++) step();
    data1 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    launch(1);
    wait_done(1, 200, lat, bcnt);
    chk_int("stab_latency", lat, 70);
    chk("stab_digest", res1, abc_dig);
    dcnt = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (done1) dcnt++;
    end
    chk_int("stab_single_done", dcnt, 0);
    chk("stab_idle", 160'(busy1), 160'(0));

    // Asynchronous reset mid-hash
    data1 = abc_blk;
    launch(1);
    for (int i = 0; i < 40; i++) step();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 160'(busy1), 160'(0));
    chk("midrst_done", 160'(done1), 160'(0));
    chk("midrst_res", res1, '0);
    chk("midrst_res2", res2, '0);
    #2 rst_n = 1'b1;
    step();
    dcnt = 0;
    for (int i = 0; i < 90; i++) begin
      step();
      if (done1) dcnt++;
    end
    chk_int("midrst_no_done", dcnt, 0);
    launch(1);
    wait_done(1, 200, lat, bcnt);
    chk_int("postrst_latency", lat, 81);
    chk("postrst_digest", res1, abc_dig);

    // Back-to-back: new start on the cycle after done
    data1 = empty_blk;
    launch(1);
    chk("b2b_busy", 160'(busy1), 160'(1));
    chk("b2b_hold_start", res1, abc_dig);
    for (int i = 0; i < 40; i++) step();
    chk("b2b_hold_mid", res1, abc_dig);
    wait_done(1, 200, lat, bcnt);
    chk_int("b2b_latency", lat, 41);
    chk("b2b_digest", res1, empty_dig);
    data1 = abc_blk;
    launch(1);
    wait_done(1, 200, lat, bcnt);
    chk_int("b2b2_latency", lat, 81);
    chk("b2b2_digest", res1, abc_dig);

    // Random blocks against the model
    for (int n = 0; n < 4; n++) begin
      for (int j = 0; j < 16; j++) rnd_blk[511 - 32*j -: 32] = $urandom;
      data1 = rnd_blk;
      launch(1);
      wait_done(1, 200, lat, bcnt);
      chk_int("rnd1_latency", lat, 81);
      chk("rnd1_digest", res1, sha1_model({rnd_blk, 512'h0}, 1));
    end
    for (int n = 0; n < 3; n++) begin
      for (int j = 0; j < 32; j++) rnd2[1023 - 32*j -: 32] = $urandom;
      data2 = rnd2;
      launch(2);
      wait_done(2, 400, lat, bcnt);
      chk_int("rnd2_latency", lat, 162);
      chk("rnd2_digest", res2, sha1_model(rnd2, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
